// File: rtl/tempsense_pkg.sv
// tempsense_pkg
//   Shared definitions for the temperature-sense path.
//   Contents:
//     RESULT_W       - width of a captured count (16)
//     ACC_W          - width of the averaging accumulator (18)
//     AVG_COUNT      - measurements per averaged report (4)
//     RESULT_TIMEOUT - RESULT value reported when a measurement overflowed
//     state_t/ST_*   - sequencer state encoding
//     group_mean()   - divide an accumulated group sum by AVG_COUNT
package tempsense_pkg;

  localparam int RESULT_W  = 16;
  localparam int AVG_COUNT = 4;
  localparam int ACC_W     = RESULT_W + $clog2(AVG_COUNT);

  localparam logic [RESULT_W-1:0] RESULT_TIMEOUT = 16'hFFFF;

  // Sequencer states. Kept as plain constants so the encoding is fixed and
  // visible on the debug port without any enum casting.
  typedef logic [3:0] state_t;
  localparam state_t ST_INIT   = 4'd0;
  localparam state_t ST_IDLE   = 4'd1;
  localparam state_t ST_DISCH  = 4'd2;
  localparam state_t ST_ARM    = 4'd3;
  localparam state_t ST_MEAS   = 4'd4;
  localparam state_t ST_CAPT   = 4'd5;
  localparam state_t ST_CLEAR  = 4'd6;
  localparam state_t ST_REPORT = 4'd7;
  localparam state_t ST_WAIT   = 4'd8;

  // AVG_COUNT is a power of two, so the mean is the top RESULT_W bits.
  function automatic logic [RESULT_W-1:0] group_mean(input logic [ACC_W-1:0] sum);
    return sum[ACC_W-1 -: RESULT_W];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Generic two-flop synchronizer for a single asynchronous level signal.
//   Ports:
//     clk   - destination clock
//     rst_n - asynchronous active-low reset (both flops load RESET_VAL)
//     d     - asynchronous input
//     q     - synchronized output, two clk edges of latency
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tempsense_sequencer.sv
// tempsense_sequencer
//   Measurement sequencer for the temperature-sense path: discharge the RC
//   network, start the shared time counter, wait for the comparator or an
//   overflow, capture the count, reset the counter and hand the result to
//   the host. Sole driver of the time counter's start/reset controls.
//
//   Build option: define TEMPSENSE_AVG_EN to run four measurements per
//   report and return their mean (a timeout aborts the group).
//
//   Parameters:
//     DISCHARGE_CYCLES - cycles DISCHARGE is held high per measurement (>=1)
//     INTERVAL_CYCLES  - idle cycles after an accepted result (1..2^24)
//   Ports:
//     MCLK, nRESET     - clock (rising edge), async active-low reset
//     ENABLE           - run request, looked at only in IDLE and WAIT
//     SENSE_IN         - async comparator output, high = threshold crossed
//     DISCHARGE        - high = discharge RC network
//     TC_nSTART        - time-counter start, one-cycle active-low pulse
//     TC_nRESET        - time-counter reset, active-low
//     TC_TIMEELAPSED   - time-counter value
//     TC_OVFL          - time-counter overflow
//     RESULT, TIMEOUT  - captured count / overflow qualifier
//     RESULT_VALID     - result offered to host
//     RESULT_ACK       - host accepts result
//     BUSY             - high in every state except IDLE
//     state_dbg        - current FSM state (ST_* encoding)
//
//   Result handshake: RESULT_VALID rises in REPORT and stays high until
//   RESULT_ACK is sampled high on a rising MCLK edge; that edge is the
//   transfer and RESULT_VALID is low from the next cycle. ACK may already be
//   high when VALID rises, in which case the first VALID cycle transfers.
//   RESULT/TIMEOUT are stable while VALID is high and until the next capture.
module tempsense_sequencer
  import tempsense_pkg::*;
#(
  parameter int DISCHARGE_CYCLES = 1024,
  parameter int INTERVAL_CYCLES  = 65536
) (
  input  logic        MCLK,
  input  logic        nRESET,
  input  logic        ENABLE,
  input  logic        SENSE_IN,
  output logic        DISCHARGE,
  output logic        TC_nSTART,
  output logic        TC_nRESET,
  input  logic [15:0] TC_TIMEELAPSED,
  input  logic        TC_OVFL,
  output logic [15:0] RESULT,
  output logic        RESULT_VALID,
  input  logic        RESULT_ACK,
  output logic        TIMEOUT,
  output logic        BUSY,
  output logic [3:0]  state_dbg
);

  localparam int DISCH_W = (DISCHARGE_CYCLES > 1) ? $clog2(DISCHARGE_CYCLES) : 1;
  localparam int WAIT_W  = (INTERVAL_CYCLES  > 1) ? $clog2(INTERVAL_CYCLES)  : 1;
  localparam logic [DISCH_W-1:0] DISCH_LOAD = DISCH_W'(DISCHARGE_CYCLES - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LOAD  = WAIT_W'(INTERVAL_CYCLES - 1);

  logic               sense;
  state_t             state, state_next;
  logic [DISCH_W-1:0] disch_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               timeout_flag;
  logic               group_done;

  sync_2ff #(.RESET_VAL(1'b0)) u_sense_sync (
    .clk   (MCLK),
    .rst_n (nRESET),
    .d     (SENSE_IN),
    .q     (sense)
  );

  assign state_dbg = state;

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT:   state_next = ST_IDLE;
      ST_IDLE:   if (ENABLE) state_next = ST_DISCH;
      ST_DISCH:  if (disch_cnt == '0) state_next = ST_ARM;
      ST_ARM:    state_next = ST_MEAS;
      ST_MEAS:   if (TC_OVFL || sense) state_next = ST_CAPT;
      ST_CAPT:   state_next = ST_CLEAR;
      // group_done is always set unless a multi-measurement group is
      // still in progress, in which case the next discharge follows at once.
      ST_CLEAR:  state_next = group_done ? ST_REPORT : ST_DISCH;
      ST_REPORT: if (RESULT_ACK) state_next = ST_WAIT;
      ST_WAIT:   if (wait_cnt == '0) state_next = ENABLE ? ST_DISCH : ST_IDLE;
      default:   state_next = ST_INIT;
    endcase
  end

  // State register and control outputs. Outputs are decoded from the next
  // state into flops so they line up exactly with the state register.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state        <= ST_INIT;
      DISCHARGE    <= 1'b0;
      TC_nSTART    <= 1'b1;
      TC_nRESET    <= 1'b0;
      RESULT_VALID <= 1'b0;
      BUSY         <= 1'b1;
    end else begin
      state        <= state_next;
      DISCHARGE    <= (state_next == ST_DISCH);
      TC_nSTART    <= (state_next != ST_ARM);
      TC_nRESET    <= !((state_next == ST_INIT) || (state_next == ST_CLEAR));
      RESULT_VALID <= (state_next == ST_REPORT);
      BUSY         <= (state_next != ST_IDLE);
    end
  end

  // Discharge and interval down-counters, loaded on entry to their state.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      disch_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if ((state_next == ST_DISCH) && (state != ST_DISCH))
        disch_cnt <= DISCH_LOAD;
      else if ((state == ST_DISCH) && (disch_cnt != '0))
        disch_cnt <= disch_cnt - DISCH_W'(1);

      if ((state_next == ST_WAIT) && (state != ST_WAIT))
        wait_cnt <= WAIT_LOAD;
      else if ((state == ST_WAIT) && (wait_cnt != '0))
        wait_cnt <= wait_cnt - WAIT_W'(1);
    end
  end

  // Remembers why MEAS ended; overflow takes priority over sense because it
  // is sampled directly as the flag value on the exit edge.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET)
      timeout_flag <= 1'b0;
    else if (state == ST_MEAS)
      timeout_flag <= TC_OVFL;
  end

`ifdef TEMPSENSE_AVG_EN
  localparam logic [1:0] GRP_LAST = 2'(AVG_COUNT - 1);

  logic [1:0]       grp_cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic             group_start;

  assign acc_sum     = acc + ACC_W'(TC_TIMEELAPSED);
  assign group_start = ((state == ST_IDLE) || (state == ST_WAIT)) && (state_next == ST_DISCH);

  // A timeout ends the group at once; the counter is still cleared in CLEAR
  // before the report so it is left in its reset state.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      grp_cnt    <= '0;
      acc        <= '0;
      group_done <= 1'b0;
      RESULT     <= '0;
      TIMEOUT    <= 1'b0;
    end else if (group_start) begin
      grp_cnt    <= '0;
      acc        <= '0;
      group_done <= 1'b0;
    end else if (state == ST_CAPT) begin
      if (timeout_flag) begin
        RESULT     <= RESULT_TIMEOUT;
        TIMEOUT    <= 1'b1;
        group_done <= 1'b1;
      end else begin
        acc <= acc_sum;
        if (grp_cnt == GRP_LAST) begin
          RESULT     <= group_mean(acc_sum);
          TIMEOUT    <= 1'b0;
          group_done <= 1'b1;
        end else begin
          grp_cnt    <= grp_cnt + 2'd1;
          group_done <= 1'b0;
        end
      end
    end
  end
`else
  assign group_done = 1'b1;

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      RESULT  <= '0;
      TIMEOUT <= 1'b0;
    end else if (state == ST_CAPT) begin
      RESULT  <= timeout_flag ? RESULT_TIMEOUT : TC_TIMEELAPSED;
      TIMEOUT <= timeout_flag;
    end
  end
`endif

endmodule

// File: doc/tempsense_sequencer.md
# tempsense_sequencer

Measurement sequencer for the temperature-sense path. Repeatedly discharges the RC thermistor network, starts the shared elapsed-time counter, waits for the sense comparator to trip or the counter to overflow, then captures the count. It returns the counter to its reset state and offers the result to the host logic over a valid/ack handshake. It sits between the host-side status logic and the time counter, and is the only driver of the counter's start/reset controls.

## Interface
- DISCHARGE_CYCLES, 1024: MCLK cycles the DISCHARGE output is held high before each measurement (≥1).
- INTERVAL_CYCLES, 65536: MCLK cycles idled between an accepted result and the next discharge (≥1, ≤2^24).
- MCLK  in  1  master clock; all logic on its rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- ENABLE  in  1  run request; sampled only in IDLE and WAIT.
- SENSE_IN  in  1  comparator output, asynchronous to MCLK; high = threshold crossed.
- DISCHARGE  out  1  high = discharge RC network.
- TC_nSTART  out  1  time-counter start, active-low, one-cycle pulse.
- TC_nRESET  out  1  time-counter reset, active-low.
- TC_TIMEELAPSED  in  16  counter value.
- TC_OVFL  in  1  counter overflow flag.
- RESULT  out  16  captured count (0xFFFF on timeout).
- RESULT_VALID  out  1  result available.
- RESULT_ACK  in  1  host accepts result.
- TIMEOUT  out  1  qualifies RESULT: measurement ended by TC_OVFL.
- BUSY  out  1  high in every state except IDLE.

## Operation
- SENSE_IN passes through a 2-FF synchronizer. All references to "sense" mean the synchronized value.
- States: INIT, IDLE, DISCH, ARM, MEAS, CAPT, CLEAR, REPORT, WAIT.
- INIT: entered on reset. Drives TC_nRESET=0 for one cycle, then goes to IDLE.
- IDLE: if ENABLE=1, go to DISCH.
- DISCH: DISCHARGE=1 for exactly DISCHARGE_CYCLES cycles, then go to ARM.
- ARM: TC_nSTART=0 for one cycle, then go to MEAS.
- MEAS: wait for sense=1 or TC_OVFL=1.
  - If both occur in the same cycle, TC_OVFL wins.
  - On TC_OVFL, go to CAPT with the timeout flag set.
  - On sense, go to CAPT with the timeout flag clear.
- CAPT: RESULT <= TC_TIMEELAPSED, or 0xFFFF if timed out. TIMEOUT <= flag. Then go to CLEAR.
- CLEAR: TC_nRESET=0 for one cycle, then go to REPORT.
- REPORT: RESULT_VALID=1 until RESULT_ACK is sampled high, then go to WAIT. No new measurement starts while a result is unaccepted.
- WAIT: count INTERVAL_CYCLES cycles.
  - If ENABLE=1 at the end of the count, go to DISCH.
  - Otherwise go to IDLE.
- ENABLE falling during DISCH..REPORT has no effect; the current measurement completes and is reported.
- Sense already high at entry to MEAS: capture on the first MEAS cycle. A RESULT of 0 is legal and is reported normally.

## Timing
- Reset values: DISCHARGE=0, TC_nSTART=1, TC_nRESET=0, RESULT=0, RESULT_VALID=0, TIMEOUT=0, BUSY=1. All outputs are registered.
- After nRESET deasserts, TC_nRESET stays 0 for one more cycle (INIT), then goes to 1.
- IDLE→DISCH: 1 cycle after ENABLE=1 is sampled.
- SENSE_IN rising edge to CAPT: 2–3 cycles (synchronizer plus MEAS decision).
- CAPT to RESULT_VALID=1: 2 cycles (CLEAR, then REPORT).
- RESULT_VALID falls on the cycle after RESULT_ACK is sampled high. An ACK already high when VALID rises is accepted in that first cycle.
- RESULT and TIMEOUT hold their values until the next CAPT.
- Interval counter width: ceil(log2(INTERVAL_CYCLES)).
- Discharge counter width: ceil(log2(DISCHARGE_CYCLES)).

## Configuration
- TEMPSENSE_AVG_EN defined:
  - Four back-to-back DISCH..CLEAR cycles are run per report, with no WAIT between them.
  - Captured counts are summed into an 18-bit accumulator; RESULT = sum[17:2].
  - Any timeout aborts the group immediately: RESULT=0xFFFF, TIMEOUT=1, go to REPORT.
  - The accumulator clears on entry from IDLE or WAIT.
- TEMPSENSE_AVG_EN undefined:
  - One measurement per report.
  - No accumulator or group counter is built.

## Structure
- Shared package tempsense_pkg holds:
  - the state enum;
  - RESULT_TIMEOUT = 16'hFFFF;
  - the result width (16);
  - the accumulator width (18) and AVG_COUNT = 4.
- Sub-module sync_2ff: a generic 2-flop synchronizer for SENSE_IN, reusable elsewhere in the tempsense path.
- Everything else lives in one module: the FSM plus the discharge, interval and (optional) group counters.

## Test plan
- Basic measurement:
  - Stimulus: DISCHARGE_CYCLES=8, INTERVAL_CYCLES=16; model counter returns 0x0123; raise SENSE_IN 50 cycles after TC_nSTART.
  - Required: RESULT=0x0123, TIMEOUT=0, RESULT_VALID 2 cycles after CAPT, one TC_nRESET pulse in CLEAR.
- Timeout:
  - Stimulus: SENSE_IN held low; assert TC_OVFL.
  - Required: RESULT=0xFFFF, TIMEOUT=1, TC_nRESET pulse issued.
- Simultaneous events:
  - Stimulus: synchronized sense and TC_OVFL rise in the same cycle.
  - Required: TIMEOUT=1, RESULT=0xFFFF.
- Handshake backpressure:
  - Stimulus: hold RESULT_ACK low for 100 cycles.
  - Required: RESULT_VALID stays 1, no DISCHARGE or TC_nSTART activity; ACK high → VALID low next cycle, then WAIT of 16 cycles, then DISCHARGE=1.
- Mid-operation reset:
  - Stimulus: assert nRESET during MEAS.
  - Required: all outputs take reset values immediately; TC_nRESET=0 until one cycle after release; next measurement proceeds normally.
- With TEMPSENSE_AVG_EN:
  - Stimulus 1: counts 100, 101, 102, 105.
  - Required 1: RESULT=102, exactly one RESULT_VALID.
  - Stimulus 2: timeout on the second measurement of a group.
  - Required 2: RESULT=0xFFFF, TIMEOUT=1.
